// File: rtl/risc8_uart_rx_pkg.sv
// rtl/risc8_uart_rx_pkg.sv - register offsets, status bit map and receiver state encoding
package risc8_uart_rx_pkg;

   localparam logic [6:0] REG_DATA   = 7'd0;
   localparam logic [6:0] REG_STATUS = 7'd1;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_OVR      = 1;
   localparam int ST_FERR     = 2;
   localparam int ST_FULL     = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } rx_state_t;

   function automatic logic [7:0] status_byte(input logic full, input logic ferr,
                                              input logic ovr, input logic nonempty);
      logic [7:0] s;
      s              = 8'h00;
      s[ST_FULL]     = full;
      s[ST_FERR]     = ferr;
      s[ST_OVR]      = ovr;
      s[ST_NONEMPTY] = nonempty;
      return s;
   endfunction

endpackage

// File: rtl/risc8_fifo.sv
// rtl/risc8_fifo.sv - power-of-two FIFO with occupancy count; pop on empty is ignored,
// a push while full is accepted only when a pop frees the slot in the same cycle.
module risc8_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/risc8_uart_rx.sv
// rtl/risc8_uart_rx.sv - 8N1 serial receiver with receive FIFO and data/status IO registers
module risc8_uart_rx
   import risc8_uart_rx_pkg::*;
#(
   parameter logic [6:0] BASE    = 7'h2C,
   parameter int         DIVISOR = 104,
   parameter int         DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] addr,
   input  logic       ren,
   input  logic       wen,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       valid,
   input  logic       rx_in
);

   localparam logic [6:0]  DATA_ADDR = BASE + REG_DATA;
   localparam logic [6:0]  STAT_ADDR = BASE + REG_STATUS;
   localparam logic [15:0] CNT_HALF  = 16'(DIVISOR / 2 - 1);
   localparam logic [15:0] CNT_FULL  = 16'(DIVISOR - 1);

   rx_state_t   state_q;
   logic        sync1_q;
   logic        sync2_q;
   logic        last_q;
   logic [15:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        push_q;
   logic        ferr_evt_q;

   logic        ovr_q;
   logic        ovr_d;
   logic        ferr_q;
   logic        ferr_d;
   logic [7:0]  rdata_q;
   logic        valid_q;

   logic        rd_data;
   logic        rd_stat;
   logic        wr_stat;
   logic        ovr_set;
   logic [7:0]  fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic        unused_wdata;

   assign unused_wdata = ^{wdata[7:3], wdata[0]};

   // Receive FSM samples only the synchronized line; push/error are registered pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         last_q     <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         push_q     <= 1'b0;
         ferr_evt_q <= 1'b0;
      end else begin
         sync1_q    <= rx_in;
         sync2_q    <= sync1_q;
         last_q     <= sync2_q;
         push_q     <= 1'b0;
         ferr_evt_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (last_q && !sync2_q) begin
                  state_q <= S_START;
                  cnt_q   <= CNT_HALF;
               end
            end
            S_START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else if (!sync2_q) begin
                  state_q <= S_DATA;
                  cnt_q   <= CNT_FULL;
                  bit_q   <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else begin
                  shift_q <= {sync2_q, shift_q[7:1]};
                  cnt_q   <= CNT_FULL;
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 16'd1;
               end else begin
                  state_q <= S_IDLE;
                  if (sync2_q) begin
                     push_q <= 1'b1;
                  end else begin
                     ferr_evt_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_data = ren && (addr == DATA_ADDR);
   assign rd_stat = ren && (addr == STAT_ADDR);
   assign wr_stat = wen && (addr == STAT_ADDR);
   // A full FIFO always has a head, so any data read in the same cycle frees the slot.
   assign ovr_set = push_q && fifo_full && !rd_data;

   risc8_fifo #(
      .WIDTH(8),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_q),
      .pop_i   (rd_data),
      .wdata_i (shift_q),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
      if (wr_stat) begin
         if (wdata[ST_FERR]) ferr_d = 1'b0;
         if (wdata[ST_OVR])  ovr_d  = 1'b0;
      end
      if (ovr_set)    ovr_d  = 1'b1;
      if (ferr_evt_q) ferr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         rdata_q <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         valid_q <= rd_data || rd_stat;
         if (rd_data) begin
            rdata_q <= fifo_empty ? 8'h00 : fifo_head;
         end else if (rd_stat) begin
            rdata_q <= status_byte(fifo_full, ferr_q, ovr_q, fifo_count != '0);
         end else begin
            rdata_q <= 8'h00;
         end
      end
   end

   assign rdata = rdata_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_risc8_uart_rx.sv
// tb/tb_risc8_uart_rx.sv - directed scenarios plus random traffic against a queue-based model
module tb_risc8_uart_rx;

   localparam int         DIV    = 4;
   localparam int         DEPTH  = 4;
   localparam logic [6:0] A_DATA = 7'h2C;
   localparam logic [6:0] A_STAT = 7'h2D;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] addr  = '0;
   logic       ren   = 1'b0;
   logic       wen   = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       valid;
   logic       rx_in = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mq[$];
   logic       m_ovr  = 1'b0;
   logic       m_ferr = 1'b0;

   risc8_uart_rx #(
      .BASE    (A_DATA),
      .DIVISOR (DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .ren   (ren),
      .wen   (wen),
      .wdata (wdata),
      .rdata (rdata),
      .valid (valid),
      .rx_in (rx_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic void m_reset();
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endfunction

   function automatic void m_frame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok) m_ferr = 1'b1;
      else if (mq.size() >= DEPTH) m_ovr = 1'b1;
      else mq.push_back(b);
   endfunction

   // Returns {valid, rdata} for a read of address a.
   function automatic logic [8:0] m_read(input logic [6:0] a);
      logic [7:0] d;
      if (a == A_DATA) begin
         d = 8'h00;
         if (mq.size() != 0) d = mq.pop_front();
         return {1'b1, d};
      end else if (a == A_STAT) begin
         d = {mq.size() == DEPTH, 4'b0000, m_ferr, m_ovr, mq.size() != 0};
         return {1'b1, d};
      end
      return 9'h000;
   endfunction

   function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
      if (a == A_STAT) begin
         if (d[2]) m_ferr = 1'b0;
         if (d[1]) m_ovr  = 1'b0;
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         idle(DIV);
      end
      rx_in = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [6:0] a);
      logic [8:0] e;
      e    = m_read(a);
      addr = a;
      ren  = 1'b1;
      idle(1);
      ren  = 1'b0;
      addr = '0;
      check({tag, "_valid"}, valid, e[8]);
      check({tag, "_rdata"}, rdata, e[7:0]);
      idle(1);
      check({tag, "_valid_drop"}, valid, 1'b0);
   endtask

   task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wen   = 1'b1;
      idle(1);
      wen   = 1'b0;
      addr  = '0;
      m_write(a, d);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
      send_frame(b, stop_ok);
      idle(4);
      m_frame(b, stop_ok);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       ok;
      logic [6:0] a;

      idle(3);
      check("rst_valid", valid, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      reset = 1'b1;
      idle(3);
      rd_chk("rst_status", A_STAT);

      rx_frame(8'hA5, 1'b1);
      rd_chk("s1_status", A_STAT);
      rd_chk("s1_data", A_DATA);
      rd_chk("s1_status2", A_STAT);

      for (int i = 1; i <= 5; i++) rx_frame(8'(i * 8'h11), 1'b1);
      rd_chk("s2_status", A_STAT);
      for (int i = 0; i < 4; i++) rd_chk("s2_data", A_DATA);
      wr_reg(A_STAT, 8'h02);
      rd_chk("s2_clr", A_STAT);

      rx_frame(8'h3C, 1'b0);
      rd_chk("s3_status", A_STAT);
      rd_chk("s3_data", A_DATA);
      wr_reg(A_STAT, 8'h04);
      rd_chk("s3_clr", A_STAT);

      rx_in = 1'b0;
      idle(1);
      rx_in = 1'b1;
      idle(12);
      rd_chk("s4_status", A_STAT);
      rd_chk("s4_empty_data", A_DATA);

      for (int i = 0; i < 4; i++) rx_frame(8'($urandom), 1'b1);
      send_frame(8'h99, 1'b1);
      idle(1);
      rd_chk("s5_coinc_rd", A_DATA);
      m_frame(8'h99, 1'b1);
      idle(4);
      rd_chk("s5_status", A_STAT);
      for (int i = 0; i < 4; i++) rd_chk("s5_data", A_DATA);

      rx_in = 1'b0;
      idle(DIV);
      for (int i = 0; i < 3; i++) begin
         rx_in = (8'h5A >> i) & 8'h01;
         idle(DIV);
      end
      reset = 1'b0;
      rx_in = 1'b1;
      idle(1);
      reset = 1'b1;
      m_reset();
      idle(20);
      rd_chk("s6_status", A_STAT);
      rx_frame(8'h77, 1'b1);
      rd_chk("s6_data", A_DATA);
      rd_chk("s6_status2", A_STAT);

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0, 1: begin
               b  = 8'($urandom);
               ok = ($urandom_range(0, 7) != 0);
               rx_frame(b, ok);
            end
            2: begin
               case ($urandom_range(0, 3))
                  0, 1:    a = A_DATA;
                  2:       a = A_STAT;
                  default: a = 7'($urandom);
               endcase
               rd_chk("rand_rd", a);
            end
            default: begin
               a = ($urandom_range(0, 1) != 0) ? A_STAT : A_DATA;
               wr_reg(a, 8'($urandom));
            end
         endcase
      end
      rd_chk("rand_final_status", A_STAT);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/risc8_uart_rx.md
RISC8_UART_RX -- requirements
Module: risc8_uart_rx

Interface
REQ-001 Parameter BASE, default 7'h2C, IO address of the data register; the status register is at BASE+1.
REQ-002 Parameter DIVISOR, default 104, clocks per serial bit; legal range is 4..65535.
REQ-003 Parameter DEPTH, default 4, receive FIFO entries; must be a power of two, 2..16.
REQ-004 clk  input  1  single system clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-low (0 = reset).
REQ-006 addr  input  7  IO bus address.
REQ-007 ren  input  1  IO read strobe, one cycle.
REQ-008 wen  input  1  IO write strobe, one cycle.
REQ-009 wdata  input  8  IO write data.
REQ-010 rdata  output  8  registered read data.
REQ-011 valid  output  1  high for exactly one cycle with rdata, selecting it in the SoC read mux.
REQ-012 rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.

Function
REQ-013 rx_in shall pass through a 2-flop synchronizer before any use; its reset value is 1.
REQ-014 The receive FSM shall have four states: IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a synchronized 1->0 transition; the bit counter loads DIVISOR/2-1.
REQ-016 In START, at counter expiry: if the line is 0 go to DATA with the counter at DIVISOR-1; if the line is 1 (glitch) return to IDLE with no side effects.
REQ-017 In DATA, sample once per DIVISOR clocks, shift LSB first, and go to STOP after the 8th sample.
REQ-018 In STOP, sample after DIVISOR clocks and then return to IDLE.
- Sample 1: push the byte into the FIFO.
- Sample 0: discard the byte and set FERR.
REQ-019 A push into a full FIFO shall drop the byte and set OVR; FIFO contents are unchanged.
REQ-020 Data register read (ren and addr==BASE): rdata = FIFO head and pop one entry.
- If the FIFO is empty, rdata = 8'h00 and no pop occurs.
REQ-021 Status register read (addr==BASE+1): rdata = {FULL, 4'b0, FERR, OVR, NONEMPTY}, bits 7..0.
REQ-022 Status write (wen and addr==BASE+1): clears FERR where wdata[2]=1 and OVR where wdata[1]=1; all other writes are ignored.
REQ-023 Read latency shall be one cycle.
- rdata and valid are registered on the cycle after ren.
- valid = 0 for non-matching addresses; rdata = 0 whenever valid = 0.
REQ-024 A pop and a push in the same cycle on a full FIFO shall both succeed: pop first, the push is accepted, OVR is not set.
REQ-025 A pop and a push in the same cycle on an empty FIFO: the read returns 8'h00 and the pushed byte is stored.
REQ-026 A status write clearing a flag in the same cycle as a new error event shall leave the flag set.
REQ-027 FIFO pointers shall wrap modulo DEPTH; occupancy is tracked with a count of width log2(DEPTH)+1.
REQ-028 NONEMPTY and FULL shall reflect FIFO occupancy at the cycle of the read.

Reset
REQ-029 While reset=0 at a clock edge, the block shall clear the following:
- FSM to IDLE, counters to 0, synchronizer to 1.
- FIFO emptied, OVR=FERR=0.
- rdata=0, valid=0.
REQ-030 Reset asserted mid-frame shall abandon the frame with no push and no flag set.
- After release, reception restarts only on a fresh falling edge.

Structure
REQ-031 Register offsets (DATA=0, STATUS=1) and status bit positions shall live in the shared risc8 device defines used by all IO peripherals.
REQ-032 The FIFO shall be a sub-module risc8_fifo: parameterized width/depth, push/pop/full/empty/count, reset shared.
REQ-033 The SoC shall instantiate the block on serial_rx and add its valid/rdata to the read-response mux.

Verification (DIVISOR=4, DEPTH=4, BASE=7'h2C)
REQ-034 Scenario: frame 0xA5 with a good stop bit, then read 0x2D, then 0x2C.
- Expected: status 8'h01; data 8'hA5; next status read 8'h00.
REQ-035 Scenario: 5 frames 0x11..0x55 with no reads, then read 0x2D.
- Expected: status 8'h83 (FULL|OVR|NONEMPTY).
- Four data reads return 0x11, 0x22, 0x33, 0x44.
REQ-036 Scenario: frame 0x3C with stop bit 0.
- Expected: status 8'h04, FIFO empty.
- Write 8'h04 to 0x2D, then read 0x2D -> 8'h00.
REQ-037 Scenario: 1-clock low glitch on rx_in.
- Expected: no push, status 8'h00.
- Read 0x2C on an empty FIFO -> 8'h00 with valid high exactly one cycle after ren.
REQ-038 Scenario: FIFO full; data read coincides with the STOP-sample push of 0x99.
- Expected: OVR stays 0; the 4th subsequent read returns 0x99.
REQ-039 Scenario: reset=0 for one cycle mid-data-bits of frame 0x5A.
- Expected: status 8'h00, no byte received.
- The next full frame 0x77 is received correctly.
